// File: rtl/pattern_count_engine_if.sv
// Bus bundle between the pattern-count engine and the core/memory side.
// The engine is the memory master: it drives the address, write strobe and
// write data, and reports done plus the three result counts.
interface pattern_count_engine_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
);
    logic              start;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [CNT_W-1:0]  ctb_o;
    logic [CNT_W-1:0]  cto_o;
    logic [CNT_W-1:0]  cts_o;

    modport master (
        input  start, mem_rdata,
        output done, mem_addr, mem_we, mem_wdata, ctb_o, cto_o, cts_o
    );

    modport slave (
        output start, mem_rdata,
        input  done, mem_addr, mem_we, mem_wdata, ctb_o, cto_o, cts_o
    );
endinterface

// File: rtl/pattern_count_engine.sv
// Pattern-count accelerator. Loads a PAT_W-bit pattern from memory, streams
// BYTES message bytes (bit 7 first) and counts:
//   ctb - pattern matches lying entirely inside one byte
//   cto - bytes holding at least one within-byte match
//   cts - matches anywhere in the bit string, byte boundaries included
// Results appear on ports and are written back saturated to 8 bits.
module pattern_count_engine #(
    parameter int PAT_W    = 5,
    parameter int BYTES    = 32,
    parameter int ADDR_W   = 8,
    parameter int PAT_ADDR = 32,
    parameter int RES_ADDR = 33,
    parameter int CNT_W    = $clog2(8 * BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    pattern_count_engine_if.master bus
);
    // Window source: PAT_W-1 history bits followed by the current byte
    localparam int WIN_W = PAT_W + 7;
    // Window i (LSB index) lies inside the byte when i <= 8-PAT_W
    localparam logic [7:0] WITHIN_MASK = 8'((16'd1 << (9 - PAT_W)) - 16'd1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] PAT_A     = ADDR_W'(PAT_ADDR);
    localparam logic [ADDR_W-1:0] RES_A0    = ADDR_W'(RES_ADDR);
    localparam logic [ADDR_W-1:0] RES_A1    = ADDR_W'(RES_ADDR + 1);
    localparam logic [ADDR_W-1:0] RES_A2    = ADDR_W'(RES_ADDR + 2);

    typedef enum logic [2:0] {
        IDLE, LDPAT, SCAN, DRAIN, WR0, WR1, WR2, FIN
    } state_t;

    state_t            state_reg;
    logic              done_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [7:0]        mem_wdata_reg;
    logic [CNT_W-1:0]  ctb_reg;
    logic [CNT_W-1:0]  cto_reg;
    logic [CNT_W-1:0]  cts_reg;
    logic [PAT_W-1:0]  pat_reg;
    logic              first_byte_reg;

    logic              accept_start;
    logic              byte_valid;
    logic [WIN_W-1:0]  win_bits;
    logic [7:0]        match_vec;
    logic [7:0]        within_hit;
    logic [7:0]        cross_hit;
    logic [3:0]        ctb_inc;
    logic [3:0]        cts_inc;
    logic              cto_inc;
    logic [CNT_W-1:0]  ctb_sum;
    logic [CNT_W-1:0]  cto_sum;
    logic [CNT_W-1:0]  cts_sum;

    // start only counts when the engine is idle or parked with results
    assign accept_start = bus.start && ((state_reg == IDLE) || (state_reg == FIN));
    // Read data is a message byte one cycle after its address; address 0's
    // slot in SCAN carries the pattern byte instead
    assign byte_valid = ((state_reg == SCAN) && (mem_addr_reg != '0)) ||
                        (state_reg == DRAIN);

    generate
        if (PAT_W > 1) begin : g_hist
            logic [PAT_W-2:0] hist_reg;
            // Keep the tail of the previous byte so windows can straddle the boundary
            always_ff @(posedge clk) begin
                if (reset) begin
                    hist_reg <= '0;
                end else if (accept_start) begin
                    hist_reg <= '0;
                end else if (byte_valid) begin
                    hist_reg <= bus.mem_rdata[PAT_W-2:0];
                end
            end
            assign win_bits = {hist_reg, bus.mem_rdata};
        end else begin : g_no_hist
            assign win_bits = bus.mem_rdata;
        end
    endgenerate

    // One comparator per window ending at each of the 8 new bit positions
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_win
            assign match_vec[gi] = (win_bits[gi +: PAT_W] == pat_reg);
        end
    endgenerate

    // Boundary-crossing windows are only meaningful once a full byte is behind us
    assign within_hit = match_vec & WITHIN_MASK;
    assign cross_hit  = match_vec & (WITHIN_MASK | {8{~first_byte_reg}});

    // Population counts of the per-window hits for this byte
    always_comb begin
        ctb_inc = '0;
        cts_inc = '0;
        for (int i = 0; i < 8; i++) begin
            ctb_inc = ctb_inc + {3'd0, within_hit[i]};
            cts_inc = cts_inc + {3'd0, cross_hit[i]};
        end
    end

    assign cto_inc = |within_hit;
    assign ctb_sum = ctb_reg + CNT_W'(ctb_inc);
    assign cto_sum = cto_reg + CNT_W'(cto_inc);
    assign cts_sum = cts_reg + CNT_W'(cts_inc);

    // Memory copy of a count clamps at 255 rather than wrapping
    function automatic logic [7:0] sat8(input logic [CNT_W-1:0] x);
        logic [CNT_W+7:0] xe;
        xe = {8'd0, x};
        if (xe > (CNT_W + 8)'(255)) begin
            return 8'hFF;
        end
        return xe[7:0];
    endfunction

    // Control FSM; all bus outputs are registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            done_reg       <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            ctb_reg        <= '0;
            cto_reg        <= '0;
            cts_reg        <= '0;
            pat_reg        <= '0;
            first_byte_reg <= 1'b1;
        end else begin
            if (byte_valid) begin
                ctb_reg        <= ctb_sum;
                cto_reg        <= cto_sum;
                cts_reg        <= cts_sum;
                first_byte_reg <= 1'b0;
            end
            if (accept_start) begin
                state_reg      <= LDPAT;
                done_reg       <= 1'b0;
                mem_addr_reg   <= PAT_A;
                ctb_reg        <= '0;
                cto_reg        <= '0;
                cts_reg        <= '0;
                first_byte_reg <= 1'b1;
            end else begin
                case (state_reg)
                    LDPAT: begin
                        state_reg    <= SCAN;
                        mem_addr_reg <= '0;
                    end
                    SCAN: begin
                        if (mem_addr_reg == '0) begin
                            pat_reg <= bus.mem_rdata[PAT_W-1:0];
                        end
                        if (mem_addr_reg == LAST_ADDR) begin
                            state_reg <= DRAIN;
                        end else begin
                            mem_addr_reg <= mem_addr_reg + 1'b1;
                        end
                    end
                    DRAIN: begin
                        state_reg     <= WR0;
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= RES_A0;
                        mem_wdata_reg <= sat8(ctb_sum);
                    end
                    WR0: begin
                        state_reg     <= WR1;
                        mem_addr_reg  <= RES_A1;
                        mem_wdata_reg <= sat8(cto_reg);
                    end
                    WR1: begin
                        state_reg     <= WR2;
                        mem_addr_reg  <= RES_A2;
                        mem_wdata_reg <= sat8(cts_reg);
                    end
                    WR2: begin
                        state_reg     <= FIN;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                        done_reg      <= 1'b1;
                    end
                    default: begin
                        state_reg <= state_reg;
                    end
                endcase
            end
        end
    end

    assign bus.done      = done_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.ctb_o     = ctb_reg;
    assign bus.cto_o     = cto_reg;
    assign bus.cts_o     = cts_reg;
endmodule

// File: tb/tb_pattern_count_engine.sv
// Directed testbench for pattern_count_engine: three instances cover the
// default configuration, a saturating 3-bit/40-byte build and a 1-bit build.
module tb_pattern_count_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] ld_sel = 2'd0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;
    int         errors = 0;
    int         checks = 0;
    int         we_cnt_a = 0;

    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    logic [7:0] mem_c [0:255];

    always #5 clk = ~clk;

    pattern_count_engine_if #(.ADDR_W(8), .CNT_W(9)) bus_a ();
    pattern_count_engine_if #(.ADDR_W(8), .CNT_W(9)) bus_b ();
    pattern_count_engine_if #(.ADDR_W(8), .CNT_W(6)) bus_c ();

    pattern_count_engine #(.PAT_W(5), .BYTES(32), .ADDR_W(8), .PAT_ADDR(32),
                           .RES_ADDR(33), .CNT_W(9))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    pattern_count_engine #(.PAT_W(3), .BYTES(40), .ADDR_W(8), .PAT_ADDR(100),
                           .RES_ADDR(101), .CNT_W(9))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    pattern_count_engine #(.PAT_W(1), .BYTES(4), .ADDR_W(8), .PAT_ADDR(32),
                           .RES_ADDR(33), .CNT_W(6))
        dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    // Synchronous-read memories with a bench-side load port
    always @(posedge clk) begin
        bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
        bus_b.mem_rdata <= mem_b[bus_b.mem_addr];
        bus_c.mem_rdata <= mem_c[bus_c.mem_addr];
        if (ld_sel == 2'd1) mem_a[ld_addr] = ld_data;
        else if (bus_a.mem_we) mem_a[bus_a.mem_addr] = bus_a.mem_wdata;
        if (ld_sel == 2'd2) mem_b[ld_addr] = ld_data;
        else if (bus_b.mem_we) mem_b[bus_b.mem_addr] = bus_b.mem_wdata;
        if (ld_sel == 2'd3) mem_c[ld_addr] = ld_data;
        else if (bus_c.mem_we) mem_c[bus_c.mem_addr] = bus_c.mem_wdata;
        if (bus_a.mem_we === 1'b1) we_cnt_a++;
    end

    task automatic write_byte(input logic [1:0] sel, input int addr, input logic [7:0] data);
        @(negedge clk);
        ld_sel = sel;
        ld_addr = 8'(addr);
        ld_data = data;
        @(posedge clk);
        #1 ld_sel = 2'd0;
    endtask

    task automatic fill(input logic [1:0] sel, input int n, input logic [7:0] val,
                        input int pat_addr, input logic [7:0] pat);
        for (int i = 0; i < n; i++) write_byte(sel, i, val);
        write_byte(sel, pat_addr, pat);
    endtask

    task automatic drive_start(input int which, input logic v);
        case (which)
            0: bus_a.start = v;
            1: bus_b.start = v;
            default: bus_c.start = v;
        endcase
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0: return bus_a.done;
            1: return bus_b.done;
            default: return bus_c.done;
        endcase
    endfunction

    // Pulse start, optionally pulse it again at cycle extra_at, and count
    // cycles until done (cycle 1 is the one right after the start edge)
    task automatic run(input int which, input int extra_at, output int cyc, output logic done_early);
        @(negedge clk);
        drive_start(which, 1'b1);
        @(posedge clk);
        #1 drive_start(which, 1'b0);
        done_early = done_of(which);
        cyc = 1;
        while (done_of(which) !== 1'b1 && cyc < 200) begin
            if (cyc == extra_at) drive_start(which, 1'b1);
            @(posedge clk);
            #1 drive_start(which, 1'b0);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_a.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus_a.done); end
        checks++; if (bus_a.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", bus_a.mem_we); end
        checks++; if (bus_a.mem_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", bus_a.mem_addr); end
        checks++; if (bus_a.mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata got=%0d want=0", bus_a.mem_wdata); end
        checks++; if (bus_a.ctb_o !== 9'd0) begin errors++; $display("FAIL reset_ctb got=%0d want=0", bus_a.ctb_o); end
        checks++; if (bus_a.cto_o !== 9'd0) begin errors++; $display("FAIL reset_cto got=%0d want=0", bus_a.cto_o); end
        checks++; if (bus_a.cts_o !== 9'd0) begin errors++; $display("FAIL reset_cts got=%0d want=0", bus_a.cts_o); end
        @(negedge clk);
        reset = 1'b0;
        $display("reset: done=%b we=%b addr=%0d", bus_a.done, bus_a.mem_we, bus_a.mem_addr);
    endtask

    task automatic test_count_vectors();
        logic [7:0] vals [3];
        logic [7:0] pats [3];
        int exp_ctb [3];
        int exp_cto [3];
        int exp_cts [3];
        int cyc;
        int w0;
        logic de;
        vals = '{8'hC1, 8'h00, 8'h55};
        pats = '{8'h07, 8'h00, 8'h15};
        exp_ctb = '{0, 128, 64};
        exp_cto = '{0, 32, 32};
        exp_cts = '{31, 252, 126};
        for (int v = 0; v < 3; v++) begin
            fill(2'd1, 32, vals[v], 32, pats[v]);
            w0 = we_cnt_a;
            run(0, -1, cyc, de);
            $display("vector %0d: ctb=%0d cto=%0d cts=%0d mem=%0d,%0d,%0d cycles=%0d",
                     v, bus_a.ctb_o, bus_a.cto_o, bus_a.cts_o, mem_a[33], mem_a[34], mem_a[35], cyc);
            checks++; if (cyc != 38) begin errors++; $display("FAIL vec%0d_latency got=%0d want=38", v, cyc); end
            checks++; if (bus_a.ctb_o !== 9'(exp_ctb[v])) begin errors++; $display("FAIL vec%0d_ctb got=%0d want=%0d", v, bus_a.ctb_o, exp_ctb[v]); end
            checks++; if (bus_a.cto_o !== 9'(exp_cto[v])) begin errors++; $display("FAIL vec%0d_cto got=%0d want=%0d", v, bus_a.cto_o, exp_cto[v]); end
            checks++; if (bus_a.cts_o !== 9'(exp_cts[v])) begin errors++; $display("FAIL vec%0d_cts got=%0d want=%0d", v, bus_a.cts_o, exp_cts[v]); end
            checks++; if (mem_a[33] !== 8'(exp_ctb[v])) begin errors++; $display("FAIL vec%0d_mem_ctb got=%0d want=%0d", v, mem_a[33], exp_ctb[v]); end
            checks++; if (mem_a[34] !== 8'(exp_cto[v])) begin errors++; $display("FAIL vec%0d_mem_cto got=%0d want=%0d", v, mem_a[34], exp_cto[v]); end
            checks++; if (mem_a[35] !== 8'(exp_cts[v])) begin errors++; $display("FAIL vec%0d_mem_cts got=%0d want=%0d", v, mem_a[35], exp_cts[v]); end
            checks++; if (we_cnt_a - w0 != 3) begin errors++; $display("FAIL vec%0d_we_pulses got=%0d want=3", v, we_cnt_a - w0); end
        end
    endtask

    task automatic test_saturation();
        int cyc;
        logic de;
        fill(2'd2, 40, 8'h00, 100, 8'h00);
        run(1, -1, cyc, de);
        $display("saturation: ctb=%0d cto=%0d cts=%0d mem=%0d,%0d,%0d cycles=%0d",
                 bus_b.ctb_o, bus_b.cto_o, bus_b.cts_o, mem_b[101], mem_b[102], mem_b[103], cyc);
        checks++; if (cyc != 46) begin errors++; $display("FAIL sat_latency got=%0d want=46", cyc); end
        checks++; if (bus_b.ctb_o !== 9'd240) begin errors++; $display("FAIL sat_ctb got=%0d want=240", bus_b.ctb_o); end
        checks++; if (bus_b.cto_o !== 9'd40) begin errors++; $display("FAIL sat_cto got=%0d want=40", bus_b.cto_o); end
        checks++; if (bus_b.cts_o !== 9'd318) begin errors++; $display("FAIL sat_cts got=%0d want=318", bus_b.cts_o); end
        checks++; if (mem_b[101] !== 8'd240) begin errors++; $display("FAIL sat_mem_ctb got=%0d want=240", mem_b[101]); end
        checks++; if (mem_b[102] !== 8'd40) begin errors++; $display("FAIL sat_mem_cto got=%0d want=40", mem_b[102]); end
        checks++; if (mem_b[103] !== 8'd255) begin errors++; $display("FAIL sat_mem_cts got=%0d want=255", mem_b[103]); end
    endtask

    task automatic test_pat_w1();
        int cyc;
        logic de;
        write_byte(2'd3, 0, 8'hA5);
        write_byte(2'd3, 1, 8'hFF);
        write_byte(2'd3, 2, 8'h00);
        write_byte(2'd3, 3, 8'h81);
        write_byte(2'd3, 32, 8'hFF);
        run(2, -1, cyc, de);
        $display("pat_w1: ctb=%0d cto=%0d cts=%0d mem=%0d,%0d,%0d cycles=%0d",
                 bus_c.ctb_o, bus_c.cto_o, bus_c.cts_o, mem_c[33], mem_c[34], mem_c[35], cyc);
        checks++; if (cyc != 10) begin errors++; $display("FAIL w1_latency got=%0d want=10", cyc); end
        checks++; if (bus_c.ctb_o !== 6'd14) begin errors++; $display("FAIL w1_ctb got=%0d want=14", bus_c.ctb_o); end
        checks++; if (bus_c.cto_o !== 6'd3) begin errors++; $display("FAIL w1_cto got=%0d want=3", bus_c.cto_o); end
        checks++; if (bus_c.cts_o !== 6'd14) begin errors++; $display("FAIL w1_cts got=%0d want=14", bus_c.cts_o); end
        checks++; if (mem_c[35] !== 8'd14) begin errors++; $display("FAIL w1_mem_cts got=%0d want=14", mem_c[35]); end
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        int w0;
        logic de;
        logic done_seen;
        fill(2'd1, 32, 8'hC1, 32, 8'h07);
        for (int i = 33; i < 36; i++) write_byte(2'd1, i, 8'hEE);
        w0 = we_cnt_a;
        @(negedge clk);
        bus_a.start = 1'b1;
        @(posedge clk);
        #1 bus_a.start = 1'b0;
        cyc = 1;
        while (cyc < 15) begin
            @(posedge clk);
            #1 cyc++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1 if (bus_a.done !== 1'b0) done_seen = 1'b1;
        end
        $display("mid_scan_reset: done_seen=%b we_pulses=%0d cts=%0d mem33=%0d",
                 done_seen, we_cnt_a - w0, bus_a.cts_o, mem_a[33]);
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b want=0", done_seen); end
        checks++; if (we_cnt_a != w0) begin errors++; $display("FAIL midrst_we got=%0d want=0", we_cnt_a - w0); end
        checks++; if (mem_a[33] !== 8'hEE) begin errors++; $display("FAIL midrst_mem got=%0d want=238", mem_a[33]); end
        checks++; if (bus_a.cts_o !== 9'd0) begin errors++; $display("FAIL midrst_cts got=%0d want=0", bus_a.cts_o); end
        run(0, -1, cyc, de);
        $display("after_reset_rerun: ctb=%0d cto=%0d cts=%0d cycles=%0d", bus_a.ctb_o, bus_a.cto_o, bus_a.cts_o, cyc);
        checks++; if (cyc != 38) begin errors++; $display("FAIL rerun_latency got=%0d want=38", cyc); end
        checks++; if (bus_a.cts_o !== 9'd31) begin errors++; $display("FAIL rerun_cts got=%0d want=31", bus_a.cts_o); end
        checks++; if (mem_a[35] !== 8'd31) begin errors++; $display("FAIL rerun_mem_cts got=%0d want=31", mem_a[35]); end
    endtask

    task automatic test_start_during_scan();
        int cyc;
        logic de;
        run(0, 10, cyc, de);
        $display("start_in_scan: ctb=%0d cto=%0d cts=%0d cycles=%0d", bus_a.ctb_o, bus_a.cto_o, bus_a.cts_o, cyc);
        checks++; if (cyc != 38) begin errors++; $display("FAIL scanstart_latency got=%0d want=38", cyc); end
        checks++; if (bus_a.cto_o !== 9'd0) begin errors++; $display("FAIL scanstart_cto got=%0d want=0", bus_a.cto_o); end
        checks++; if (bus_a.cts_o !== 9'd31) begin errors++; $display("FAIL scanstart_cts got=%0d want=31", bus_a.cts_o); end
    endtask

    task automatic test_start_in_fin();
        int cyc;
        logic de;
        checks++; if (bus_a.done !== 1'b1) begin errors++; $display("FAIL fin_hold got=%b want=1", bus_a.done); end
        run(0, -1, cyc, de);
        $display("start_in_fin: done_after_start=%b ctb=%0d cto=%0d cts=%0d cycles=%0d",
                 de, bus_a.ctb_o, bus_a.cto_o, bus_a.cts_o, cyc);
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL fin_done_drop got=%b want=0", de); end
        checks++; if (cyc != 38) begin errors++; $display("FAIL fin_latency got=%0d want=38", cyc); end
        checks++; if (bus_a.ctb_o !== 9'd0) begin errors++; $display("FAIL fin_ctb got=%0d want=0", bus_a.ctb_o); end
        checks++; if (bus_a.cts_o !== 9'd31) begin errors++; $display("FAIL fin_cts got=%0d want=31", bus_a.cts_o); end
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
        test_reset();
        test_count_vectors();
        test_saturation();
        test_pat_w1();
        test_reset_mid_scan();
        test_start_during_scan();
        test_start_in_fin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pattern_count_engine.md
Name: pattern_count_engine

Overview:
- Hardware accelerator for the pattern-count workload. It scans a BYTES-long message in data memory for a PAT_W-bit pattern.
- It produces three counts:
  - ctb: matches fully inside a byte.
  - cto: bytes containing at least one match.
  - cts: matches across the whole bit-string, byte boundaries crossed.
- Sits beside the core as a data-memory master. Results are returned on ports and written back to memory.

Parameters:
- PAT_W, 5, pattern width in bits; legal range 1..8.
- BYTES, 32, message length in bytes, stored at addresses 0..BYTES-1.
- ADDR_W, 8, memory address width.
- PAT_ADDR, 32, address of the pattern byte. The pattern is the low PAT_W bits of that byte.
- RES_ADDR, 33, base address for results: ctb at +0, cto at +1, cts at +2.
- CNT_W, $clog2(8*BYTES+1), width of the count ports.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle request to begin a scan.
- done, output, 1, level; high when results are valid.
- mem_addr, output, ADDR_W, read/write address.
- mem_rdata, input, 8, read data; valid the cycle after mem_addr is presented.
- mem_we, output, 1, write enable.
- mem_wdata, output, 8, write data.
- ctb_o, output, CNT_W, within-byte match count.
- cto_o, output, CNT_W, count of bytes with at least one match.
- cts_o, output, CNT_W, count of string matches with byte crossing.

Behaviour:
- Reset: state IDLE. done=0, mem_we=0, mem_addr=0, mem_wdata=0, all counts and pattern register 0. Reset has priority over everything.
- FSM states: IDLE, LDPAT, SCAN, DRAIN, WR0, WR1, WR2, FIN.
- IDLE:
  - start=1 clears the counts and the bit history, drops done next cycle, and goes to LDPAT.
  - start is also accepted in FIN.
  - start in any other state is ignored.
- Cycle timing, with start sampled at edge T:
  - T+1: LDPAT presents mem_addr=PAT_ADDR.
  - T+2: pattern captured. SCAN presents addresses 0..BYTES-1 in cycles T+2..T+BYTES+1.
  - Byte k is processed the cycle after its address. The last byte is processed in DRAIN (T+BYTES+2).
  - WR0/WR1/WR2 at T+BYTES+3..+5 drive mem_we=1 to RES_ADDR+0/+1/+2.
  - FIN at T+BYTES+6: done=1, held until the next accepted start or reset.
  - BYTES=32 gives done at T+38.
- Per byte b (bit 7 first in the string):
  - Within-byte windows are b[i+PAT_W-1:i] for i=0..8-PAT_W. ctb += number equal to the pattern.
  - cto += 1 if any window matched.
- Cross-byte counting:
  - A history register holds the last PAT_W-1 string bits. The 8 new bits extend the string.
  - Each window ending at one of the 8 new bit positions is evaluated only when at least PAT_W string bits have been seen.
  - Total windows evaluated = 8*BYTES-PAT_W+1.
  - cts += matches.
- Write-back: each memory result byte is min(count,255); saturated, never wrapped. The ports carry full-width counts.
- Counts update only in SCAN/DRAIN. They are stable from WR0 through FIN.
- mem_we=1 only in WR0..WR2. mem_wdata=0 otherwise.
- Reset mid-scan: IDLE next cycle, no write-back, done=0.
- PAT_W=8: exactly one within-byte window. PAT_W=1: 8 windows per byte, and cts counts every matching bit.

Test Plan:
- Default params, pattern 00111, all bytes 8'b11000001, pulse start -> ctb=0, cto=0, cts=31; mem[33..35]=0,0,31; done exactly 38 cycles after start.
- Pattern 00000, all bytes 0 -> ctb=128, cto=32, cts=252.
- Pattern 10101, all bytes 8'b01010101 -> ctb=64, cto=32, cts=126.
- PAT_W=3, BYTES=40, pattern 000, all bytes 0 -> ports ctb=240, cto=40, cts=318; mem[RES_ADDR..+2]=240,40,255 (saturated).
- Default run with reset asserted at T+15 -> done stays 0, no mem_we pulse. A fresh start then yields the correct counts.
- start pulsed again at T+10 during SCAN -> ignored, same results and timing. start in FIN -> done drops next cycle, recompute matches the first results.
